// File: rtl/mux_pkg.sv
// Shared constants, FSM state type and counter helper for the registered N-way mux.
// Used by mux_nway_comb and mux_nway_reg.
package mux_pkg;

    localparam int MUX_MAX_N = 16;
    localparam int ERR_CNT_W = 8;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } mux_state_e;

    function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
        return (&v) ? v : v + ERR_CNT_W'(1);
    endfunction

endpackage

// File: rtl/mux_nway_comb.sv
// Pure combinational N-way AND-OR channel select plus out-of-range detect on sel.
// No priority between channels: each channel is gated by its own one-hot enable.
module mux_nway_comb
    import mux_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int N     = 5,
    parameter int SELW  = 3
) (
    input  logic [N*WIDTH-1:0] in_data,
    input  logic [SELW-1:0]    sel,
    output logic [WIDTH-1:0]   mux_data,
    output logic               sel_oor
);

    localparam logic [SELW:0] N_EXT = (SELW + 1)'(N);

    logic [N-1:0] onehot;

    always_comb begin
        onehot = '0;
        for (int k = 0; k < N; k++) begin
            onehot[k] = (sel == SELW'(k));
        end
    end

    // An out-of-range sel matches no enable, so the OR tree naturally yields zero.
    always_comb begin
        mux_data = '0;
        for (int k = 0; k < N; k++) begin
            mux_data = mux_data | (in_data[k*WIDTH +: WIDTH] & {WIDTH{onehot[k]}});
        end
    end

    assign sel_oor = ({1'b0, sel} >= N_EXT);

endmodule

// File: rtl/mux_nway_reg.sv
// Registered N-way mux with a one-entry valid/ready output stage and error counting.
// Optional round-robin channel scan is compiled in with `define MUX_NWAY_SCAN_EN.
module mux_nway_reg
    import mux_pkg::*;
#(
    parameter  int WIDTH = 32,
    parameter  int N     = 5,
    localparam int SELW  = (N > 2) ? $clog2(N) : 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [N*WIDTH-1:0]   in_data,
    input  logic [SELW-1:0]      sel,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 sel_err,
    output logic [ERR_CNT_W-1:0] err_cnt,
    input  logic                 scan_mode
);

    mux_state_e           state_q, state_d;
    logic [WIDTH-1:0]     out_data_q, out_data_d;
    logic                 sel_err_q, sel_err_d;
    logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

    logic [SELW-1:0]      eff_sel;
    logic [WIDTH-1:0]     mux_data;
    logic                 sel_oor;
    logic                 accept;

    assign out_valid = (state_q == ST_FULL);
    assign in_ready  = !out_valid || out_ready;
    assign accept    = in_valid && in_ready;
    assign out_data  = out_data_q;
    assign sel_err   = sel_err_q;
    assign err_cnt   = err_cnt_q;

`ifdef MUX_NWAY_SCAN_EN
    logic [SELW-1:0] ptr_q, ptr_d;

    assign eff_sel = scan_mode ? ptr_q : sel;

    // Pointer only moves on accepts made in scan mode and is never reset by toggling it.
    always_comb begin
        ptr_d = ptr_q;
        if (accept && scan_mode) begin
            ptr_d = (ptr_q == SELW'(N - 1)) ? '0 : ptr_q + SELW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`else
    logic unused_scan_mode;

    assign unused_scan_mode = scan_mode;
    assign eff_sel          = sel;
`endif

    mux_nway_comb #(
        .WIDTH (WIDTH),
        .N     (N),
        .SELW  (SELW)
    ) u_comb (
        .in_data  (in_data),
        .sel      (eff_sel),
        .mux_data (mux_data),
        .sel_oor  (sel_oor)
    );

    always_comb begin
        state_d    = state_q;
        out_data_d = out_data_q;
        sel_err_d  = sel_err_q;
        err_cnt_d  = err_cnt_q;

        case (state_q)
            ST_EMPTY: begin
                if (accept) begin
                    state_d = ST_FULL;
                end
            end
            ST_FULL: begin
                if (out_ready && !accept) begin
                    state_d = ST_EMPTY;
                end
            end
            default: state_d = ST_EMPTY;
        endcase

        // Result registers change only on accept, so a stalled result stays put.
        if (accept) begin
            out_data_d = sel_oor ? '0 : mux_data;
            sel_err_d  = sel_oor;
            if (sel_oor) begin
                err_cnt_d = sat_inc(err_cnt_q);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_EMPTY;
            out_data_q <= '0;
            sel_err_q  <= 1'b0;
            err_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            out_data_q <= out_data_d;
            sel_err_q  <= sel_err_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

endmodule
